// File: rtl/dff_arb_pkg.sv
// Package: dff_arb_pkg
// Purpose: shared sizing helpers and limits for the flop-bank write arbiter.
//   clog2_min1 : ceil(log2(value)) but never below 1, so single-entry or
//                two-entry structures still get a 1-bit index.
//   aw_of      : address width for a bank of the given depth.
//   idw_of     : requester index width for the given requester count.
//   idx_t      : index type wide enough for the largest supported requester count.
package dff_arb_pkg;

  localparam int N_MIN     = 2;
  localparam int N_MAX     = 8;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  // Ceiling log2 clamped to at least one bit so port widths never collapse to zero.
  function automatic int clog2_min1(input int value);
    if (value <= 2) begin
      return 1;
    end
    return $clog2(value);
  endfunction

  // Address width used by both the per-requester write slices and the read port.
  function automatic int aw_of(input int depth);
    return clog2_min1(depth);
  endfunction

  // Width of a requester index, as carried by grant_id and the round-robin pointer.
  function automatic int idw_of(input int n);
    return clog2_min1(n);
  endfunction

  typedef logic [$clog2(N_MAX)-1:0] idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Module: rr_arbiter
// Purpose: purely combinational round-robin pick. Searches ptr, ptr+1, ...
//   (mod N) and returns the first eligible requester.
// Ports:
//   eligible  in  N     requesters allowed to win this cycle
//   ptr       in  IDW   index with highest priority this cycle
//   grant     out N     one-hot winner (all zero when nothing eligible)
//   grant_idx out IDW   binary index of the winner (0 when nothing eligible)
//   any       out 1     at least one requester is eligible
module rr_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = idw_of(N)
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Walk the offsets from farthest to nearest so that the requester closest
  // to ptr (offset 0 first) is the last one written and therefore wins.
  // The wrap is a single conditional subtract because ptr + offset < 2N.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (sum >= (IDW + 1)'(N)) begin
        sum = sum - (IDW + 1)'(N);
      end
      idx = sum[IDW-1:0];
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Module: dff_bank_arbiter
// Purpose: shares the single write port of a DEPTH x WIDTH flop bank among N
//   requesters with round-robin arbitration, one committed write per cycle,
//   and a registered per-requester acknowledge. A combinational read port
//   exposes the bank contents.
// Ports:
//   clk       in   1         rising-edge clock
//   reset_n   in   1         asynchronous active-low reset
//   req       in   N         pending write per requester
//   wr_addr   in   N*AW      packed write address, slice i = [i*AW +: AW]
//   wr_data   in   N*WIDTH   packed write data, slice i = [i*WIDTH +: WIDTH]
//   ack       out  N         one-cycle pulse when requester i's write commits
//   err       out  1         pulses with ack when the committed address was out of range
//   grant_id  out  IDW       index of the most recently granted requester
//   busy      out  1         some requester is eligible this cycle
//   rd_addr   in   AW        read address
//   rd_data   out  WIDTH     bank[rd_addr], or 0 when rd_addr >= DEPTH
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = aw_of(DEPTH),
  localparam int IDW   = idw_of(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req,
  input  logic [N*AW-1:0]    wr_addr,
  input  logic [N*WIDTH-1:0] wr_data,
  output logic [N-1:0]       ack,
  output logic               err,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] bank [DEPTH];
  logic [IDW-1:0]   ptr;

  logic [N-1:0]     eligible;
  logic [N-1:0]     grant;
  logic [IDW-1:0]   grant_idx;
  logic             any;

  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic             win_oor;

  // A requester that is being acknowledged this cycle is still holding its
  // old request, so it is masked to keep the same write from committing twice.
  assign eligible = req & ~ack;
  assign busy     = any;

  rr_arbiter #(
    .N(N)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any)
  );

  // Route the winning requester's address and data slice onto the single
  // write port, and flag addresses beyond the bank so the write is dropped.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        win_addr = wr_addr[i*AW +: AW];
        win_data = wr_data[i*WIDTH +: WIDTH];
      end
    end
    win_oor = ({1'b0, win_addr} >= (AW + 1)'(DEPTH));
  end

  // Bank storage: one register updated per cycle at most, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        bank[j] <= '0;
      end
    end else if (any && !win_oor) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (win_addr == AW'(j)) begin
          bank[j] <= win_data;
        end
      end
    end
  end

  // Handshake and pointer state. ack/err are single-cycle pulses; grant_id
  // and the pointer only move when a grant is issued so an idle cycle keeps
  // the rotation where it left off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack      <= '0;
      err      <= 1'b0;
      grant_id <= '0;
      ptr      <= '0;
    end else if (any) begin
      ack      <= grant;
      err      <= win_oor;
      grant_id <= grant_idx;
      ptr      <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
    end else begin
      ack <= '0;
      err <= 1'b0;
    end
  end

  // Read mux over the implemented registers; unimplemented addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (rd_addr == AW'(j)) begin
        rd_data = bank[j];
      end
    end
  end

endmodule
